// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO iterative multiply/divide unit:
// FSM state encoding, op codes, default operand width and a counter-width helper.
package muldiv_pkg;

    localparam int MULDIV_WIDTH = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MULT = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    // Number of bits needed to hold values 0..value-1 (at least 1).
    function automatic int clog2(input int value);
        int bits;
        int rest;
        bits = 0;
        rest = value - 1;
        while (rest > 0) begin
            bits = bits + 1;
            rest = rest >> 1;
        end
        if (bits == 0) begin
            bits = 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the multiply/divide datapath.
// Multiply: unsigned shift-add, product kept in acc[2W-1:0], multiplier consumed from the LSB.
// Divide:   restoring shift-subtract, remainder in acc[2W:W], dividend/quotient in acc[W-1:0].
//           The quotient bit is returned separately; the top shifts it into acc[0].
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic               op_i,
    input  logic [2*WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0]   operand_i,
    output logic [2*WIDTH:0]   acc_o,
    output logic               q_bit_o
);

    logic [WIDTH:0]   add_sum;
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    // Compute both candidate iterations and select on the operation.
    always_comb begin
        add_sum = '0;
        shifted = '0;
        diff    = '0;
        acc_o   = '0;
        q_bit_o = 1'b0;
        if (op_i == OP_DIV) begin
            // Remainder shifted left with the next dividend bit appended.
            shifted = {acc_i[2*WIDTH:WIDTH], acc_i[WIDTH-1]};
            diff    = shifted - {2'b00, operand_i};
            q_bit_o = ~diff[WIDTH+1];
            acc_o   = {(q_bit_o ? diff[WIDTH:0] : shifted[WIDTH:0]),
                       acc_i[WIDTH-2:0], 1'b0};
        end else begin
            add_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
                    + (acc_i[0] ? {1'b0, operand_i} : {(WIDTH+1){1'b0}});
            acc_o   = {1'b0, add_sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/hilo_seq_muldiv.sv
// Iterative signed multiply/divide unit feeding the HI/LO registers.
// Mult: {hi_out, lo_out} = a_in * b_in.  Div: lo_out = quotient, hi_out = remainder.
// Optional macro MULDIV_UNSIGNED_EN adds is_unsigned for multu/divu behaviour.
module hilo_seq_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
`ifdef MULDIV_UNSIGNED_EN
    input  logic             is_unsigned,
`endif
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = clog2(WIDTH + 1);

    state_t             state_q;
    logic [2*WIDTH:0]   acc_q;
    logic [WIDTH-1:0]   operand_q;
    logic               sign_a_q;
    logic               sign_b_q;
    logic               op_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;
    logic               dbz_q;

    logic               signed_mode;
    logic               neg_a;
    logic               neg_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH:0]   acc_step_d;
    logic               q_bit;
    logic [2*WIDTH:0]   acc_d;
    logic [2*WIDTH-1:0] product_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

`ifdef MULDIV_UNSIGNED_EN
    assign signed_mode = ~is_unsigned;
`else
    assign signed_mode = 1'b1;
`endif

    // Operand magnitudes; the most-negative value maps onto itself as an unsigned number.
    always_comb begin
        neg_a = signed_mode & a_in[WIDTH-1];
        neg_b = signed_mode & b_in[WIDTH-1];
        mag_a = neg_a ? -a_in : a_in;
        mag_b = neg_b ? -b_in : b_in;
    end

    muldiv_step #(
        .WIDTH     (WIDTH)
    ) u_step (
        .op_i      (op_q),
        .acc_i     (acc_q),
        .operand_i (operand_q),
        .acc_o     (acc_step_d),
        .q_bit_o   (q_bit)
    );

    // Next accumulator: divide shifts the fresh quotient bit into the freed LSB.
    always_comb begin
        acc_d = acc_step_d;
        if (op_q == OP_DIV) begin
            acc_d = {acc_step_d[2*WIDTH:1], q_bit};
        end
    end

    // Sign correction of the magnitude results; latched signs are zero in unsigned mode.
    always_comb begin
        product_fix = acc_q[2*WIDTH-1:0];
        quot_fix    = acc_q[WIDTH-1:0];
        rem_fix     = acc_q[2*WIDTH-1:WIDTH];
        if (sign_a_q ^ sign_b_q) begin
            product_fix = -acc_q[2*WIDTH-1:0];
            quot_fix    = -acc_q[WIDTH-1:0];
        end
        if (sign_a_q) begin
            rem_fix = -acc_q[2*WIDTH-1:WIDTH];
        end
    end

    // Control FSM with registered busy/done/div_by_zero and the HI/LO result registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            operand_q <= '0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            op_q      <= OP_MULT;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sign_a_q <= neg_a;
                        sign_b_q <= neg_b;
                        op_q     <= op;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        if (op == OP_DIV) begin
                            acc_q     <= {{(WIDTH+1){1'b0}}, mag_a};
                            operand_q <= mag_b;
                        end else begin
                            acc_q     <= {{(WIDTH+1){1'b0}}, mag_b};
                            operand_q <= mag_a;
                        end
                        if (op == OP_DIV && b_in == '0) begin
                            // Skip the iterations; HI/LO stay untouched.
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            dbz_q   <= 1'b1;
                        end else if (op == OP_DIV) begin
                            state_q <= DIV;
                        end else begin
                            state_q <= MULT;
                        end
                    end
                end
                MULT, DIV: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (op_q == OP_DIV) begin
                        hi_q <= rem_fix;
                        lo_q <= quot_fix;
                    end else begin
                        hi_q <= product_fix[2*WIDTH-1:WIDTH];
                        lo_q <= product_fix[WIDTH-1:0];
                    end
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign hi_out      = hi_q;
    assign lo_out      = lo_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_hilo_seq_muldiv.sv
// Self-checking bench for hilo_seq_muldiv: directed operations with literal expectations,
// plus a cycle-level arithmetic model compared against the outputs on every falling edge.
module tb_hilo_seq_muldiv;

    localparam int WIDTH = 32;

    logic        clock;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int total = 0;
    int bad   = 0;
    bit tb_go = 0;

    hilo_seq_muldiv #(.WIDTH(WIDTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op          (op),
`ifdef MULDIV_UNSIGNED_EN
        .is_unsigned (1'b0),
`endif
        .a_in        (a_in),
        .b_in        (b_in),
        .hi_out      (hi_out),
        .lo_out      (lo_out),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Signed arithmetic reference from plain 64-bit integer math.
    function automatic void model_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo, output bit dz);
        longint sa;
        longint sb;
        longint r;
        logic [63:0] rv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 0;
        hi = '0;
        lo = '0;
        if (o == 1'b0) begin
            r  = sa * sb;
            rv = r;
            hi = rv[63:32];
            lo = rv[31:0];
        end else if (b == 32'd0) begin
            dz = 1;
        end else begin
            r  = sa / sb;
            rv = r;
            lo = rv[31:0];
            r  = sa % sb;
            rv = r;
            hi = rv[31:0];
        end
    endfunction

    // Timeline model: an accepted op completes (done visible) WIDTH+1 edges later,
    // or on the accepting edge itself for a divide by zero; IDLE resumes one edge after done.
    int          cyc = 0;
    bit          m_idle = 1;
    int          m_done_edge = -10;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] p_hi = '0;
    logic [31:0] p_lo = '0;
    bit          p_dbz = 0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_idle      = 1;
            m_hi        = '0;
            m_lo        = '0;
            m_done_edge = -10;
            p_dbz       = 0;
        end else begin
            cyc++;
            if (m_idle && start) begin
                model_op(op, a_in, b_in, p_hi, p_lo, p_dbz);
                m_done_edge = cyc + (p_dbz ? 0 : WIDTH + 1);
                m_idle      = 0;
            end
            if (!m_idle && cyc == m_done_edge && !p_dbz) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
            if (!m_idle && cyc == m_done_edge + 1) begin
                m_idle = 1;
            end
        end
    end

    // Cycle compare of every output against the model.
    always @(negedge clock) begin
        if (tb_go) begin
            chk("cyc_busy", {63'd0, busy}, {63'd0, !m_idle});
            chk("cyc_done", {63'd0, done}, {63'd0, (!m_idle && cyc == m_done_edge)});
            chk("cyc_dbz",  {63'd0, div_by_zero}, {63'd0, (!m_idle && cyc == m_done_edge && p_dbz)});
            chk("cyc_hi",   {32'd0, hi_out}, {32'd0, m_hi});
            chk("cyc_lo",   {32'd0, lo_out}, {32'd0, m_lo});
        end
    end

    // Issue one op from a falling edge and check its literal results.
    // Latency is the rising edge (counted from the accepting edge) at which done is sampled high.
    task automatic run_op(input string name, input logic o, input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input logic [31:0] ehi, input logic [31:0] elo,
                          input bit edbz, input int exp_busy, input int glitch_at);
        int k;
        int n;
        int lat;
        int busy_cnt;
        int done_cnt;
        bit dbz_seen;
        op    = o;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(negedge clock);
        start    = 1'b0;
        a_in     = $urandom;
        b_in     = $urandom;
        k        = cyc;
        n        = 0;
        lat      = -1;
        busy_cnt = 0;
        done_cnt = 0;
        dbz_seen = 0;
        while (busy && n < 100) begin
            if (done) begin
                done_cnt++;
                if (lat < 0) begin
                    lat      = cyc - k + 1;
                    dbz_seen = div_by_zero;
                end
            end
            busy_cnt++;
            if (glitch_at > 0 && n == glitch_at) begin
                start = 1'b1;
                op    = 1'b0;
                a_in  = 32'd3;
                b_in  = 32'd3;
            end else begin
                start = 1'b0;
            end
            n++;
            @(negedge clock);
        end
        start = 1'b0;
        chk({name, "_timeout"}, {63'd0, (n >= 100)}, 64'd0);
        chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({name, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
        chk({name, "_done_count"}, 64'(done_cnt), 64'd1);
        chk({name, "_dbz"}, {63'd0, dbz_seen}, {63'd0, edbz});
        chk({name, "_hi"}, {32'd0, hi_out}, {32'd0, ehi});
        chk({name, "_lo"}, {32'd0, lo_out}, {32'd0, elo});
        $display("op %s: op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0d latency=%0d",
                 name, o, a, b, hi_out, lo_out, dbz_seen, lat);
    endtask

    initial begin
        int extra;
        reset = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        a_in  = '0;
        b_in  = '0;
        #1 reset = 1'b1;
        tb_go = 1;
        @(negedge clock);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_dbz",  {63'd0, div_by_zero}, 64'd0);
        chk("reset_hi",   {32'd0, hi_out}, 64'd0);
        chk("reset_lo",   {32'd0, lo_out}, 64'd0);
        #2 reset = 1'b0;
        @(negedge clock);

        run_op("mul_7_m3",     1'b0, 32'd7,        32'hFFFFFFFD, 34, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 34, 0);
        run_op("mul_max_max",  1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 34, 32'h3FFFFFFF, 32'h00000001, 0, 34, 0);
        run_op("mul_min_min",  1'b0, 32'h80000000, 32'h80000000, 34, 32'h40000000, 32'h00000000, 0, 34, 0);
        run_op("div_m7_2",     1'b1, 32'hFFFFFFF9, 32'd2,        34, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 34, 0);
        run_op("div_100_7",    1'b1, 32'd100,      32'd7,        34, 32'd2,        32'd14,       0, 34, 0);
        run_op("div_m100_m7",  1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 34, 32'hFFFFFFFE, 32'd14,       0, 34, 0);
        run_op("div_7_m2",     1'b1, 32'd7,        32'hFFFFFFFE, 34, 32'd1,        32'hFFFFFFFD, 0, 34, 0);
        run_op("div_prime",    1'b1, 32'h451,      32'h20,       34, 32'h11,       32'h22,       0, 34, 0);
        run_op("div_by_zero",  1'b1, 32'd5,        32'd0,        1,  32'h11,       32'h22,       1, 1,  0);
        run_op("div_min_m1",   1'b1, 32'h80000000, 32'hFFFFFFFF, 34, 32'h00000000, 32'h80000000, 0, 34, 5);

        // A start pulsed mid-operation must not produce a second result.
        extra = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) extra++;
        end
        chk("ignored_start_extra_done", 64'(extra), 64'd0);
        chk("ignored_start_busy", {63'd0, busy}, 64'd0);

        // Reset in the middle of a multiply discards everything.
        op    = 1'b0;
        a_in  = 32'h1234;
        b_in  = 32'h5678;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (10) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("midreset_busy", {63'd0, busy}, 64'd0);
        chk("midreset_done", {63'd0, done}, 64'd0);
        chk("midreset_hi",   {32'd0, hi_out}, 64'd0);
        chk("midreset_lo",   {32'd0, lo_out}, 64'd0);
        $display("reset applied mid-multiply: busy=%0d hi=%h lo=%h", busy, hi_out, lo_out);
        @(negedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        run_op("mul_3_4",      1'b0, 32'd3,        32'd4,        34, 32'd0,        32'd12,       0, 34, 0);

        repeat (3) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
